// File: rtl/data_memory_bytelane.sv
// RV32 data memory with byte/half lanes and a request/acknowledge debug port.
// Optional macro DMEM_MISALIGN_TRAP_EN: flag, suppress and zero misaligned CPU accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no debug request held; samples i_dbg_req
// S_PEND  | request captured; waits for an edge without a CPU store
// S_FORCE | starvation limit hit; CPU stalled, debug access wins next edge
// S_ACK   | one-cycle completion pulse; request input ignored
module data_memory_bytelane #(
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = 8,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   i_cpu_addr,
  input  logic [31:0]   i_cpu_wdata,
  input  logic          i_cpu_we,
  input  logic          i_cpu_re,
  input  logic [2:0]    i_cpu_funct3,
  output logic [31:0]   o_cpu_rdata,
  output logic          o_cpu_misaligned,
  output logic          o_cpu_stall,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [31:0]   i_dbg_wdata,
  output logic          o_dbg_busy,
  output logic          o_dbg_ack,
  output logic [31:0]   o_dbg_rdata,
  output logic [31:0]   o_mem0
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FORCE, S_ACK} state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_dbg_we;
  logic [AW-1:0] r_dbg_addr;
  logic [31:0]   r_dbg_wdata;
  logic [31:0]   r_dbg_rdata;
  logic          r_dbg_busy;
  logic          r_dbg_ack;
  logic          r_cpu_stall;

  // Zero at time 0 only; reset deliberately leaves the contents alone.
  logic [31:0]   r_mem [DEPTH] = '{default: '0};

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic          w_ld_block;
  logic          w_st_block;
  logic [3:0]    w_be;
  logic [31:0]   w_st_data;
  logic          w_dbg_svc;
  logic          w_unused;

  assign w_idx    = i_cpu_addr[AW+1:2];
  assign w_off    = i_cpu_addr[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_byte   = w_word[{w_off, 3'b000} +: 8];
  assign w_half   = i_cpu_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_unused = ^i_cpu_addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_mis_ld;
  logic w_mis_st;

  always_comb begin
    w_mis_ld = 1'b0;
    w_mis_st = 1'b0;
    case (i_cpu_funct3)
      3'b001: begin
        w_mis_ld = w_off[0];
        w_mis_st = w_off[0];
      end
      3'b101: w_mis_ld = w_off[0];
      3'b010: begin
        w_mis_ld = (w_off != 2'b00);
        w_mis_st = (w_off != 2'b00);
      end
      default: ;
    endcase
  end

  assign w_ld_block       = w_mis_ld;
  assign w_st_block       = w_mis_st;
  assign o_cpu_misaligned = (i_cpu_re & w_mis_ld) | (i_cpu_we & w_mis_st);
`else
  assign w_ld_block       = 1'b0;
  assign w_st_block       = 1'b0;
  assign o_cpu_misaligned = 1'b0;
`endif

  always_comb begin
    o_cpu_rdata = '0;
    if (!reset && i_cpu_re && !w_ld_block) begin
      case (i_cpu_funct3)
        3'b000:  o_cpu_rdata = {{24{w_byte[7]}}, w_byte};
        3'b100:  o_cpu_rdata = {24'h0, w_byte};
        3'b001:  o_cpu_rdata = {{16{w_half[15]}}, w_half};
        3'b101:  o_cpu_rdata = {16'h0, w_half};
        3'b010:  o_cpu_rdata = w_word;
        default: o_cpu_rdata = '0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte mask alone selects the target.
  always_comb begin
    w_be      = 4'b0000;
    w_st_data = i_cpu_wdata;
    case (i_cpu_funct3)
      3'b000: begin
        w_be      = 4'b0001 << w_off;
        w_st_data = {4{i_cpu_wdata[7:0]}};
      end
      3'b001: begin
        w_be      = i_cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{i_cpu_wdata[15:0]}};
      end
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    if (reset || !i_cpu_we || (r_state == S_FORCE) || w_st_block)
      w_be = 4'b0000;
  end

  assign w_dbg_svc = ((r_state == S_PEND) && !i_cpu_we) || (r_state == S_FORCE);

  always_ff @(posedge clk) begin
    if (w_dbg_svc && r_dbg_we) begin
      r_mem[r_dbg_addr] <= r_dbg_wdata;
    end else begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_dbg_we     <= 1'b0;
      r_dbg_addr   <= '0;
      r_dbg_wdata  <= '0;
      r_dbg_rdata  <= '0;
      r_dbg_busy   <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_cpu_stall  <= 1'b0;
    end else begin
      r_dbg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_dbg_req) begin
            r_dbg_we     <= i_dbg_we;
            r_dbg_addr   <= i_dbg_addr;
            r_dbg_wdata  <= i_dbg_wdata;
            r_dbg_busy   <= 1'b1;
            r_starve_cnt <= '0;
            r_state      <= S_PEND;
          end
        end
        S_PEND: begin
          if (!i_cpu_we) begin
            if (!r_dbg_we) r_dbg_rdata <= r_mem[r_dbg_addr];
            r_dbg_ack  <= 1'b1;
            r_dbg_busy <= 1'b0;
            r_state    <= S_ACK;
          end else if (r_starve_cnt == CW'(STARVE_LIMIT)) begin
            r_cpu_stall <= 1'b1;
            r_state     <= S_FORCE;
          end else begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
          end
        end
        S_FORCE: begin
          if (!r_dbg_we) r_dbg_rdata <= r_mem[r_dbg_addr];
          r_dbg_ack   <= 1'b1;
          r_dbg_busy  <= 1'b0;
          r_cpu_stall <= 1'b0;
          r_state     <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cpu_stall = r_cpu_stall;
  assign o_dbg_busy  = r_dbg_busy;
  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_rdata = r_dbg_rdata;
  assign o_mem0      = r_mem[0];

endmodule
